// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package mdu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division step on unsigned magnitudes; purely combinational.
// Shifts the next dividend bit into the partial remainder and emits one quotient bit.
module mdu_divstep import mdu_pkg::*; (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;

    // rem_in < divisor always holds, so diff[XLEN] is exactly the borrow.
    assign rem_sh  = {rem_in, quo_in[XLEN-1]};
    assign diff    = rem_sh - {1'b0, divisor};
    assign rem_out = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_out = {quo_in[XLEN-2:0], ~diff[XLEN]};

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M MUL/DIV: 33-cycle latency (1 for div special cases, and for MUL* with
// MDU_FAST_MUL_EN); start is ignored while busy, results go out on a registered write port.
module mdu_iter import mdu_pkg::*; #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd,
    output logic            busy,
    output logic            done,
    output logic            wb_we,
    output logic [4:0]      wb_waddr,
    output logic [XLEN-1:0] wb_wdata
);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        f3_q;
    logic [4:0]        rd_q;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opnd;
    logic              a_neg_q;
    logic              res_neg_q;

    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            is_div, div_zero, div_ovf;
    logic [XLEN-1:0] special_res;

    assign a_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                      (funct3 == F3_DIV) || (funct3 == F3_REM);
    assign b_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
                      (funct3 == F3_DIV) || (funct3 == F3_REM);
    assign a_neg    = a_signed & op_a[XLEN-1];
    assign b_neg    = b_signed & op_b[XLEN-1];
    assign mag_a    = a_neg ? -op_a : op_a;
    assign mag_b    = b_neg ? -op_b : op_b;

    assign is_div   = funct3[2];
    assign div_zero = (op_b == '0);
    assign div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                      (op_a == INT_MIN) && (&op_b);
    assign special_res = div_zero ? (funct3[1] ? op_a : '1)
                                  : (funct3[1] ? '0 : INT_MIN);

    // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_nxt, mul_fix;
    logic [XLEN-1:0]   mul_res;

    assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_nxt = {mul_sum, acc[XLEN-1:1]};
    assign mul_fix = res_neg_q ? -mul_nxt : mul_nxt;
    assign mul_res = (f3_q == F3_MUL) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];

    logic [XLEN-1:0] rem_nxt, quo_nxt, div_res;

    mdu_divstep u_divstep (
        .rem_in  (acc[2*XLEN-1:XLEN]),
        .quo_in  (acc[XLEN-1:0]),
        .divisor (opnd),
        .rem_out (rem_nxt),
        .quo_out (quo_nxt)
    );

    assign div_res = f3_q[1] ? (a_neg_q ? -rem_nxt : rem_nxt)
                             : (res_neg_q ? -quo_nxt : quo_nxt);

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod, fast_fix;
    logic [XLEN-1:0]   fast_res;

    assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
    assign fast_fix  = (a_neg ^ b_neg) ? -fast_prod : fast_prod;
    assign fast_res  = (funct3 == F3_MUL) ? fast_fix[XLEN-1:0] : fast_fix[2*XLEN-1:XLEN];
`endif

    logic            fin_vld;
    logic [4:0]      fin_rd;
    logic [XLEN-1:0] fin_res;

    always_comb begin
        fin_vld = 1'b0;
        fin_rd  = rd_q;
        fin_res = '0;
        case (state)
            S_IDLE: begin
                fin_rd = rd;
                if (start && is_div && (div_zero || div_ovf)) begin
                    fin_vld = 1'b1;
                    fin_res = special_res;
                end
`ifdef MDU_FAST_MUL_EN
                if (start && !is_div) begin
                    fin_vld = 1'b1;
                    fin_res = fast_res;
                end
`endif
            end
            S_MUL: if (cnt == CNT_W'(1)) begin
                fin_vld = 1'b1;
                fin_res = mul_res;
            end
            S_DIV: if (cnt == CNT_W'(1)) begin
                fin_vld = 1'b1;
                fin_res = div_res;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            f3_q      <= '0;
            rd_q      <= '0;
            acc       <= '0;
            opnd      <= '0;
            a_neg_q   <= 1'b0;
            res_neg_q <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wb_we     <= 1'b0;
            wb_waddr  <= '0;
            wb_wdata  <= '0;
        end else begin
            done  <= 1'b0;
            wb_we <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    f3_q      <= funct3;
                    rd_q      <= rd;
                    cnt       <= CNT_W'(XLEN);
                    a_neg_q   <= a_neg;
                    res_neg_q <= a_neg ^ b_neg;
                    busy      <= 1'b1;
                    if (is_div) begin
                        acc   <= {{XLEN{1'b0}}, mag_a};
                        opnd  <= mag_b;
                        state <= S_DIV;
                    end else begin
                        acc   <= {{XLEN{1'b0}}, mag_b};
                        opnd  <= mag_a;
                        state <= S_MUL;
                    end
                end
                S_MUL: begin
                    acc <= mul_nxt;
                    cnt <= cnt - CNT_W'(1);
                end
                S_DIV: begin
                    acc <= {rem_nxt, quo_nxt};
                    cnt <= cnt - CNT_W'(1);
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            if (fin_vld) begin
                state    <= S_DONE;
                done     <= 1'b1;
                wb_we    <= (fin_rd != 5'd0);
                wb_waddr <= fin_rd;
                wb_wdata <= fin_res;
            end
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: hand-computed RV32M results, latencies and control corner cases.
module tb_mdu_iter;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic [4:0]  rd;
    logic        busy, done, wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;

    int checks = 0;
    int failures = 0;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    always #5 clk = ~clk;

    mdu_iter #(.XLEN(32), .CNT_W(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .funct3   (funct3),
        .op_a     (op_a),
        .op_b     (op_b),
        .rd       (rd),
        .busy     (busy),
        .done     (done),
        .wb_we    (wb_we),
        .wb_waddr (wb_waddr),
        .wb_wdata (wb_wdata)
    );

    int          lat;
    logic        we_s;
    logic [4:0]  wa_s;
    logic [31:0] wd_s;

    // Issue one op from a negedge, scramble inputs after accept, capture the done cycle.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r);
        funct3 = f; op_a = a; op_b = b; rd = r; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; op_a = ~a; op_b = ~b; rd = ~r;
        lat = -1; we_s = 1'bx; wa_s = 'x; wd_s = 'x;
        for (int k = 1; k <= 40; k++) begin
            if (done) begin
                lat = k; we_s = wb_we; wa_s = wb_waddr; wd_s = wb_wdata;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset done: got %b want 0", done); end
        checks++; if (wb_we !== 1'b0) begin failures++; $display("FAIL reset wb_we: got %b want 0", wb_we); end
        checks++; if (wb_waddr !== 5'd0) begin failures++; $display("FAIL reset wb_waddr: got %0d want 0", wb_waddr); end
        checks++; if (wb_wdata !== 32'd0) begin failures++; $display("FAIL reset wb_wdata: got %h want 0", wb_wdata); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul();
        logic [2:0]  fv [5];
        logic [31:0] av [5], bv [5], ev [5];
        fv = '{F3_MUL, F3_MULH, F3_MULHU, F3_MULHSU, F3_MUL};
        av = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD};
        bv = '{32'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5};
        ev = '{32'h0000002A, 32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF1};
        for (int i = 0; i < 5; i++) begin
            run_op(fv[i], av[i], bv[i], 5'(5 + i));
            checks++; if (lat != MUL_LAT) begin failures++; $display("FAIL mul[%0d] latency: got %0d want %0d", i, lat, MUL_LAT); end
            checks++; if (wd_s !== ev[i]) begin failures++; $display("FAIL mul[%0d] wdata: got %h want %h", i, wd_s, ev[i]); end
            checks++; if (we_s !== 1'b1) begin failures++; $display("FAIL mul[%0d] wb_we: got %b want 1", i, we_s); end
            checks++; if (wa_s !== 5'(5 + i)) begin failures++; $display("FAIL mul[%0d] waddr: got %0d want %0d", i, wa_s, 5 + i); end
        end
    endtask

    task automatic test_div();
        logic [2:0]  fv [6];
        logic [31:0] av [6], bv [6], ev [6];
        fv = '{F3_DIV, F3_REM, F3_DIVU, F3_REMU, F3_DIV, F3_REM};
        av = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd100, 32'd100};
        bv = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9};
        ev = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFF2, 32'd2};
        for (int i = 0; i < 6; i++) begin
            run_op(fv[i], av[i], bv[i], 5'(20 + i));
            checks++; if (lat != 33) begin failures++; $display("FAIL div[%0d] latency: got %0d want 33", i, lat); end
            checks++; if (wd_s !== ev[i]) begin failures++; $display("FAIL div[%0d] wdata: got %h want %h", i, wd_s, ev[i]); end
            checks++; if (we_s !== 1'b1 || wa_s !== 5'(20 + i)) begin failures++; $display("FAIL div[%0d] write port: got we=%b waddr=%0d want we=1 waddr=%0d", i, we_s, wa_s, 20 + i); end
        end
    endtask

    task automatic test_special();
        logic [2:0]  fv [6];
        logic [31:0] av [6], bv [6], ev [6];
        fv = '{F3_DIVU, F3_REMU, F3_DIV, F3_REM, F3_DIV, F3_REM};
        av = '{32'h1234, 32'h1234, 32'h80000000, 32'h80000000, 32'd5, 32'hFFFFFFF9};
        bv = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
        ev = '{32'hFFFFFFFF, 32'h1234, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9};
        for (int i = 0; i < 6; i++) begin
            run_op(fv[i], av[i], bv[i], 5'(10 + i));
            checks++; if (lat != 1) begin failures++; $display("FAIL special[%0d] latency: got %0d want 1", i, lat); end
            checks++; if (wd_s !== ev[i]) begin failures++; $display("FAIL special[%0d] wdata: got %h want %h", i, wd_s, ev[i]); end
            checks++; if (we_s !== 1'b1 || wa_s !== 5'(10 + i)) begin failures++; $display("FAIL special[%0d] write port: got we=%b waddr=%0d want we=1 waddr=%0d", i, we_s, wa_s, 10 + i); end
        end
    endtask

    task automatic test_start_held();
        int   writes = 0;
        int   dlat = -1;
        logic busy_after = 1'bx;
        logic [31:0] dwd = 'x;
        logic [4:0]  dwa = 'x;
        funct3 = F3_DIVU; op_a = 32'd100; op_b = 32'd7; rd = 5'd9; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 1; k <= 40; k++) begin
            if (k == 5) begin funct3 = F3_MUL; op_a = 32'd50; op_b = 32'd3; rd = 5'd4; end
            if (wb_we) writes++;
            if (dlat > 0 && k == dlat + 1) busy_after = busy;
            if (done && dlat < 0) begin dlat = k; dwd = wb_wdata; dwa = wb_waddr; start = 1'b0; end
            @(negedge clk);
        end
        start = 1'b0;
        checks++; if (dlat != 33) begin failures++; $display("FAIL held latency: got %0d want 33", dlat); end
        checks++; if (dwd !== 32'd14 || dwa !== 5'd9) begin failures++; $display("FAIL held result: got %h@%0d want 0000000e@9", dwd, dwa); end
        checks++; if (writes != 1) begin failures++; $display("FAIL held writes: got %0d want 1", writes); end
        checks++; if (busy_after !== 1'b0) begin failures++; $display("FAIL held busy after done: got %b want 0", busy_after); end
    endtask

    task automatic test_reset_mid();
`ifndef MDU_FAST_MUL_EN
        int seen = 0;
        funct3 = F3_MUL; op_a = 32'd5; op_b = 32'd5; rd = 5'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < 10; k++) begin
            if (done || wb_we) seen++;
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if ({busy, done, wb_we} !== 3'b000) begin failures++; $display("FAIL midreset flags: got busy/done/we=%b want 000", {busy, done, wb_we}); end
        checks++; if (wb_waddr !== 5'd0 || wb_wdata !== 32'd0) begin failures++; $display("FAIL midreset write port: got %h@%0d want 0@0", wb_wdata, wb_waddr); end
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (done || wb_we) seen++;
            @(negedge clk);
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL midreset aborted op completed: got %0d done/we cycles want 0", seen); end
`endif
        run_op(F3_MUL, 32'd9, 32'd9, 5'd3);
        checks++; if (lat != MUL_LAT) begin failures++; $display("FAIL post-reset latency: got %0d want %0d", lat, MUL_LAT); end
        checks++; if (wd_s !== 32'd81 || we_s !== 1'b1 || wa_s !== 5'd3) begin failures++; $display("FAIL post-reset result: got %h we=%b@%0d want 00000051 we=1@3", wd_s, we_s, wa_s); end
    endtask

    task automatic test_rd_zero();
        run_op(F3_MUL, 32'd3, 32'd4, 5'd0);
        checks++; if (lat != MUL_LAT) begin failures++; $display("FAIL rd0 latency: got %0d want %0d", lat, MUL_LAT); end
        checks++; if (we_s !== 1'b0) begin failures++; $display("FAIL rd0 wb_we: got %b want 0", we_s); end
        checks++; if (wd_s !== 32'd12) begin failures++; $display("FAIL rd0 wdata: got %h want 0000000c", wd_s); end
        checks++; if (done !== 1'b0 || wb_wdata !== 32'd12) begin failures++; $display("FAIL rd0 after done: got done=%b wdata=%h want done=0 wdata=0000000c", done, wb_wdata); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_start_held();
        test_reset_mid();
        test_rd_zero();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
